// File: rtl/byte_stream_aligner_pkg.sv
// Shared types, sizes and byte-mask helpers for the byte stream aligner.
// The optional zero fill of tail bytes is enabled by defining ALIGNER_ZERO_FILL_EN.
package byte_stream_aligner_pkg;

  localparam int DATA_BYTES = 16;
  localparam int OFF_W      = 4;
  localparam int CNT_W      = 5;
  localparam int DATA_W     = DATA_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Lanes below 16-off come from the held beat, the rest from the incoming one.
  function automatic logic [DATA_BYTES-1:0] merge_mask(input logic [OFF_W-1:0] off);
    logic [DATA_BYTES-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_BYTES; j++) m[j] = (j < DATA_BYTES - int'(off));
    return m;
  endfunction

  function automatic logic [DATA_BYTES-1:0] tail_mask(input logic [CNT_W-1:0] cnt);
    logic [DATA_BYTES-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_BYTES; j++) m[j] = (j < int'(cnt));
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] expand_mask(input logic [DATA_BYTES-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < DATA_BYTES; j++) r[8*j +: 8] = {8{m[j]}};
    return r;
  endfunction

endpackage

// File: rtl/byte_stream_aligner_rotate.sv
// Combinational byte rotate right: output byte j = input byte (j+shift) mod DATA_BYTES.
module byte_rotate_r
  import byte_stream_aligner_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [OFF_W-1:0]  shift_i,
  output logic [DATA_W-1:0] data_o
);

  // Shifting a doubled copy gives the wrap-around without a per-lane mux.
  assign data_o = DATA_W'({data_i, data_i} >> {shift_i, 3'b000});

endmodule

// File: rtl/byte_stream_aligner.sv
// Realigns an offset byte stream into packed offset-0 beats with a registered output.
// Define ALIGNER_ZERO_FILL_EN to force bytes at or above out_bytes to zero on last beats.
module byte_stream_aligner
  import byte_stream_aligner_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic              in_last,
  input  logic [CNT_W-1:0]  in_last_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_bytes,
  output logic              err
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [CNT_W-1:0]    lastb_q, lastb_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [CNT_W-1:0]    out_bytes_q, out_bytes_d;
  logic                err_q, err_d;

  logic                out_free, accept;
  logic [DATA_W-1:0]   rot_hold, rot_in, merge_w, merged;
  logic                load, load_last;
  logic [DATA_W-1:0]   load_data, fill_data;
  logic [CNT_W-1:0]    load_bytes;

  byte_rotate_r u_rot_hold (.data_i(hold_q),  .shift_i(off_q), .data_o(rot_hold));
  byte_rotate_r u_rot_in   (.data_i(in_data), .shift_i(off_q), .data_o(rot_in));

  assign merge_w  = expand_mask(merge_mask(off_q));
  assign merged   = (rot_hold & merge_w) | (rot_in & ~merge_w);

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = out_free && (state_q != FLUSH);
  assign accept   = in_valid && in_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    off_d      = off_q;
    lastb_d    = lastb_q;
    err_d      = 1'b0;
    load       = 1'b0;
    load_data  = rot_hold;
    load_last  = 1'b0;
    load_bytes = CNT_W'(DATA_BYTES);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_first) begin
            err_d = 1'b1;
          end else begin
            hold_d = in_data;
            off_d  = in_offset;
            if (!in_last) begin
              state_d = STREAM;
            end else if (in_last_bytes > CNT_W'(in_offset)) begin
              lastb_d = in_last_bytes;
              state_d = FLUSH;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (accept) begin
          err_d     = in_first;
          load      = 1'b1;
          load_data = merged;
          hold_d    = in_data;
          if (in_last && (in_last_bytes <= CNT_W'(off_q))) begin
            load_last  = 1'b1;
            load_bytes = CNT_W'(DATA_BYTES) - CNT_W'(off_q) + in_last_bytes;
            state_d    = IDLE;
          end else if (in_last) begin
            lastb_d = in_last_bytes;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load       = 1'b1;
          load_last  = 1'b1;
          load_bytes = lastb_q - CNT_W'(off_q);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ALIGNER_ZERO_FILL_EN
    fill_data = load_last ? (load_data & expand_mask(tail_mask(load_bytes))) : load_data;
`else
    fill_data = load_data;
`endif

    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_bytes_d = out_bytes_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fill_data;
      out_last_d  = load_last;
      out_bytes_d = load_bytes;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // hold_q is cleared on reset as well, so an aborted packet leaves no residue behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      off_q       <= '0;
      lastb_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bytes_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      off_q       <= off_d;
      lastb_q     <= lastb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_bytes_q <= out_bytes_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_bytes = out_bytes_q;
  assign err       = err_q;

endmodule

// File: tb/tb_byte_stream_aligner.sv
// Directed and randomized bench for byte_stream_aligner with a packed-byte reference model.
module tb_byte_stream_aligner;
  import byte_stream_aligner_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [4:0]   bytes;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_first, in_last;
  logic [127:0] in_data;
  logic [3:0]   in_offset;
  logic [4:0]   in_last_bytes;
  logic         out_valid, out_ready, out_last, err;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;

  int    n_total = 0;
  int    n_pass  = 0;
  int    err_cnt = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  beat_t act_q[$];
  beat_t exp_q[$];
  logic  stalled = 1'b0;
  beat_t prev;

  byte_stream_aligner dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .in_offset(in_offset), .in_last(in_last), .in_last_bytes(in_last_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bytes(out_bytes), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] seq_beat(input int base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(base + k);
    return r;
  endfunction

  function automatic logic [127:0] byte_mask(input int n);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = (k < n) ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Output side: drives out_ready at each falling edge, records handshakes and checks stall stability.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #1;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (stalled) begin
          n_total++;
          if (out_data !== prev.data || out_last !== prev.last || out_bytes !== prev.bytes)
            $display("FAIL stall_stable: got %h/%b/%0d want %h/%b/%0d",
                     out_data, out_last, out_bytes, prev.data, prev.last, prev.bytes);
          else n_pass++;
        end
        prev = '{out_data, out_last, out_bytes};
        if (out_ready) act_q.push_back(prev);
        stalled = !out_ready;
      end else begin
        stalled = 1'b0;
      end
      if (rst_n === 1'b1 && err === 1'b1) err_cnt++;
    end
  end

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic drive_beat(input logic [127:0] d, input logic f, input logic [3:0] o,
                            input logic l, input logic [4:0] lb);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_first = f; in_offset = o; in_last = l; in_last_bytes = lb;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL in_ready_timeout: in_ready stayed %b for %0d cycles, want 1", in_ready, waited);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_act(input int n, input int budget);
    int c = 0;
    while (act_q.size() < n && c < budget) begin
      @(negedge clk); c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_offset = '0;
    in_last = 1'b0; in_last_bytes = '0;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0)  $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_total++; if (err !== 1'b0)       $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_total++; if (out_data !== '0)    $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (out_bytes !== 5'd0) $display("FAIL rst_out_bytes: got %0d want 0", out_bytes); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_total++; if (in_ready !== 1'b1)  $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_offset0();
    beat_t e[3];
    e[0] = '{seq_beat(0), 1'b0, 5'd16};
    e[1] = '{seq_beat(16), 1'b0, 5'd16};
    e[2] = '{seq_beat(32), 1'b1, 5'd16};
    ready_mode = 0; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(0),  1'b1, 4'd0, 1'b0, 5'd0);
    drive_beat(seq_beat(16), 1'b0, 4'd0, 1'b0, 5'd0);
    drive_beat(seq_beat(32), 1'b0, 4'd0, 1'b1, 5'd16);
    wait_act(3, 50);
    n_total++; if (act_q.size() != 3) $display("FAIL off0_count: got %0d want 3", act_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < act_q.size(); i++) begin
      n_total++;
      if ((act_q[i].data & byte_mask(e[i].bytes)) !== (e[i].data & byte_mask(e[i].bytes)) ||
          act_q[i].last !== e[i].last || act_q[i].bytes !== e[i].bytes)
        $display("FAIL off0_beat%0d: got %h/%b/%0d want %h/%b/%0d", i, act_q[i].data, act_q[i].last,
                 act_q[i].bytes, e[i].data, e[i].last, e[i].bytes);
      else n_pass++;
    end
  endtask

  task automatic test_offset5();
    beat_t e[3];
    e[0] = '{seq_beat(5), 1'b0, 5'd16};
    e[1] = '{seq_beat(21), 1'b0, 5'd16};
    e[2] = '{seq_beat(37), 1'b1, 5'd11};
    ready_mode = 0; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(0),  1'b1, 4'd5, 1'b0, 5'd0);
    drive_beat(seq_beat(16), 1'b0, 4'd0, 1'b0, 5'd0);
    drive_beat(seq_beat(32), 1'b0, 4'd0, 1'b1, 5'd16);
    wait_act(3, 50);
    n_total++; if (act_q.size() != 3) $display("FAIL off5_count: got %0d want 3", act_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < act_q.size(); i++) begin
      n_total++;
      if ((act_q[i].data & byte_mask(e[i].bytes)) !== (e[i].data & byte_mask(e[i].bytes)) ||
          act_q[i].last !== e[i].last || act_q[i].bytes !== e[i].bytes)
        $display("FAIL off5_beat%0d: got %h/%b/%0d want %h/%b/%0d", i, act_q[i].data, act_q[i].last,
                 act_q[i].bytes, e[i].data, e[i].last, e[i].bytes);
      else n_pass++;
    end
  endtask

  task automatic test_offset12_short_tail();
    ready_mode = 0; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(0),  1'b1, 4'd12, 1'b0, 5'd0);
    drive_beat(seq_beat(16), 1'b0, 4'd0,  1'b1, 5'd4);
    wait_act(1, 50);
    n_total++; if (act_q.size() != 1) $display("FAIL off12_count: got %0d want 1", act_q.size()); else n_pass++;
    if (act_q.size() > 0) begin
      n_total++;
      if ((act_q[0].data & byte_mask(8)) !== (seq_beat(12) & byte_mask(8)) ||
          act_q[0].last !== 1'b1 || act_q[0].bytes !== 5'd8)
        $display("FAIL off12_beat: got %h/%b/%0d want %h/1/8", act_q[0].data, act_q[0].last,
                 act_q[0].bytes, seq_beat(12));
      else n_pass++;
    end
  endtask

  task automatic test_single_and_errors();
    int e0;
    ready_mode = 0; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(0), 1'b1, 4'd2, 1'b1, 5'd10);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else n_pass++;
    wait_act(1, 50);
    n_total++; if (act_q.size() != 1) $display("FAIL single_count: got %0d want 1", act_q.size()); else n_pass++;
    if (act_q.size() > 0) begin
      n_total++;
      if ((act_q[0].data & byte_mask(8)) !== (seq_beat(2) & byte_mask(8)) ||
          act_q[0].last !== 1'b1 || act_q[0].bytes !== 5'd8)
        $display("FAIL single_beat: got %h/%b/%0d want %h/1/8", act_q[0].data, act_q[0].last,
                 act_q[0].bytes, seq_beat(2));
      else n_pass++;
    end
    act_q.delete(); e0 = err_cnt;
    drive_beat(seq_beat(0), 1'b1, 4'd2, 1'b1, 5'd2);
    wait_act(1, 6);
    n_total++; if (err_cnt - e0 != 1) $display("FAIL zero_pkt_err: got %0d pulses want 1", err_cnt - e0); else n_pass++;
    n_total++; if (act_q.size() != 0) $display("FAIL zero_pkt_out: got %0d beats want 0", act_q.size()); else n_pass++;
    e0 = err_cnt;
    drive_beat(seq_beat(64), 1'b0, 4'd0, 1'b0, 5'd0);
    wait_act(1, 6);
    n_total++; if (err_cnt - e0 != 1) $display("FAIL no_first_err: got %0d pulses want 1", err_cnt - e0); else n_pass++;
    n_total++; if (act_q.size() != 0) $display("FAIL no_first_out: got %0d beats want 0", act_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    beat_t e[2];
    e[0] = '{seq_beat(7), 1'b0, 5'd16};
    e[1] = '{seq_beat(23), 1'b1, 5'd9};
    ready_mode = 2; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(100), 1'b1, 4'd3, 1'b0, 5'd0);
    drive_beat(seq_beat(116), 1'b0, 4'd0, 1'b0, 5'd0);
    #1;
    n_total++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", out_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; ready_mode = 0; act_q.delete();
    @(negedge clk);
    drive_beat(seq_beat(0),  1'b1, 4'd7, 1'b0, 5'd0);
    drive_beat(seq_beat(16), 1'b0, 4'd0, 1'b1, 5'd16);
    wait_act(2, 50);
    n_total++; if (act_q.size() != 2) $display("FAIL post_reset_count: got %0d want 2", act_q.size()); else n_pass++;
    for (int i = 0; i < 2 && i < act_q.size(); i++) begin
      n_total++;
      if ((act_q[i].data & byte_mask(e[i].bytes)) !== (e[i].data & byte_mask(e[i].bytes)) ||
          act_q[i].last !== e[i].last || act_q[i].bytes !== e[i].bytes)
        $display("FAIL post_reset_beat%0d: got %h/%b/%0d want %h/%b/%0d", i, act_q[i].data,
                 act_q[i].last, act_q[i].bytes, e[i].data, e[i].last, e[i].bytes);
      else n_pass++;
    end
  endtask

  task automatic test_random_backpressure();
    logic [7:0]   bq[$];
    logic [127:0] d;
    int o, n, l, lo, hi, e0, bad;
    beat_t b;
    ready_mode = 1; act_q.delete(); exp_q.delete(); e0 = err_cnt; bad = 0;
    @(negedge clk);
    for (int p = 0; p < 1000; p++) begin
      o = $urandom_range(0, 15);
      n = $urandom_range(1, 4);
      l = (n == 1) ? $urandom_range(o + 1, 16) : $urandom_range(1, 16);
      for (int bi = 0; bi < n; bi++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        lo = (bi == 0) ? o : 0;
        hi = (bi == n - 1) ? l : 16;
        for (int k = lo; k < hi; k++) bq.push_back(d[8*k +: 8]);
        drive_beat(d, bi == 0, 4'(o), bi == n - 1, 5'(l));
      end
      while (bq.size() > 0) begin
        b.data = '0;
        b.bytes = 5'(bq.size() > 16 ? 16 : bq.size());
        for (int k = 0; k < int'(b.bytes); k++) b.data[8*k +: 8] = bq.pop_front();
        b.last = (bq.size() == 0);
        exp_q.push_back(b);
      end
    end
    wait_act(exp_q.size(), 4000);
    n_total++;
    if (act_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d beats want %0d", act_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_total++;
      if ((act_q[i].data & byte_mask(exp_q[i].bytes)) !== (exp_q[i].data & byte_mask(exp_q[i].bytes)) ||
          act_q[i].last !== exp_q[i].last || act_q[i].bytes !== exp_q[i].bytes) begin
        if (bad < 10)
          $display("FAIL rand_beat%0d: got %h/%b/%0d want %h/%b/%0d", i, act_q[i].data, act_q[i].last,
                   act_q[i].bytes, exp_q[i].data, exp_q[i].last, exp_q[i].bytes);
        bad++;
      end else n_pass++;
    end
    n_total++; if (err_cnt != e0) $display("FAIL rand_err: got %0d pulses want 0", err_cnt - e0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_offset5();
    test_offset12_short_tail();
    test_single_and_errors();
    test_reset_mid_packet();
    test_random_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
